// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit FIFO slice.
//   txState_t      - transmit sequencer state encodings
//   UART_TXF_DEPTH - default FIFO depth
//   LO / HI        - logic level constants
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ISSUE     = 2'b01,
        WAIT_BUSY = 2'b10,
        WAIT_DONE = 2'b11
    } txState_t;

    localparam int UART_TXF_DEPTH = 16;

    localparam logic LO = 1'b0;
    localparam logic HI = 1'b1;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x 8 byte storage for the UART transmit FIFO.
// One synchronous write port and an asynchronous read of the head entry.
// The storage array has no reset; pointers in the parent define validity.
// Ports:
//   sys_clk  - clock, rising edge
//   wrEnH    - write enable
//   wrAddrH  - write address (write pointer)
//   wrDataH  - byte to store
//   rdAddrH  - read address (read pointer)
//   rdDataH  - byte at rdAddrH, combinational
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          sys_clk,
    input  logic          wrEnH,
    input  logic [AW-1:0] wrAddrH,
    input  logic [7:0]    wrDataH,
    input  logic [AW-1:0] rdAddrH,
    output logic [7:0]    rdDataH
);

    logic [7:0] memArray [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (wrEnH) begin
            memArray[wrAddrH] <= wrDataH;
        end
    end

    assign rdDataH = memArray[rdAddrH];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: host-side byte FIFO feeding a UART transmitter through a
// small handshake sequencer.
// Optional build macro: UART_TXF_STATUS_EN adds txf_levelH and ovflH.
// Ports:
//   sys_clk     - clock, rising edge
//   sys_rst_l   - asynchronous reset, active low
//   wr_enH      - host write strobe, one byte per cycle
//   wr_dataH    - host byte to enqueue
//   fullH       - FIFO holds DEPTH bytes
//   emptyH      - FIFO holds no bytes
//   tx_idleH    - FIFO empty and sequencer idle
//   xmitH       - one-cycle start request to the transmitter
//   xmit_dataH  - byte presented to the transmitter
//   xmit_doneH  - transmitter done level, low while a frame is in flight
//   txf_levelH  - (UART_TXF_STATUS_EN) current occupancy
//   ovflH       - (UART_TXF_STATUS_EN) sticky: a write was dropped while full
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a queued byte; pops head into xmit_dataH
// ISSUE     | xmitH high for exactly one cycle
// WAIT_BUSY | waiting for the transmitter to drop xmit_doneH
// WAIT_DONE | frame in flight, waiting for xmit_doneH to return high
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_TXF_DEPTH,
    parameter int AW    = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_l,
    input  logic       wr_enH,
    input  logic [7:0] wr_dataH,
    output logic       fullH,
    output logic       emptyH,
    output logic       tx_idleH,
    output logic       xmitH,
    output logic [7:0] xmit_dataH,
    input  logic       xmit_doneH
`ifdef UART_TXF_STATUS_EN
    ,
    output logic [AW:0] txf_levelH,
    output logic        ovflH
`endif
);

    txState_t      state;
    txState_t      stateNext;
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic [7:0]    headData;
    logic          wrAccept;
    logic          pop;

    assign fullH    = (count == (AW+1)'(DEPTH));
    assign emptyH   = (count == '0);
    assign tx_idleH = emptyH & (state == IDLE);

    // A write while full is dropped even if the sequencer pops this cycle.
    assign wrAccept = wr_enH & ~fullH;
    assign pop      = (state == IDLE) & ~emptyH;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .sys_clk (sys_clk),
        .wrEnH   (wrAccept),
        .wrAddrH (wrPtr),
        .wrDataH (wr_dataH),
        .rdAddrH (rdPtr),
        .rdDataH (headData)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrAccept) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({wrAccept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:      if (!emptyH)            stateNext = ISSUE;
            ISSUE:                             stateNext = WAIT_BUSY;
            WAIT_BUSY: if (xmit_doneH == LO)   stateNext = WAIT_DONE;
            WAIT_DONE: if (xmit_doneH == HI)   stateNext = IDLE;
            default:                           stateNext = IDLE;
        endcase
    end

    // xmitH is registered from the next-state decode so it is high exactly
    // while the state register holds ISSUE.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state      <= IDLE;
            xmitH      <= LO;
            xmit_dataH <= 8'h00;
        end else begin
            state <= stateNext;
            xmitH <= (stateNext == ISSUE);
            if (pop) begin
                xmit_dataH <= headData;
            end
        end
    end

`ifdef UART_TXF_STATUS_EN
    assign txf_levelH = count;

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            ovflH <= LO;
        end else if (wr_enH && fullH) begin
            ovflH <= HI;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo.
// Issued bytes are checked against a scoreboard queue filled as bytes are
// written; the fill-to-full sequence is table driven.
// Optional build macro: UART_TXF_STATUS_EN (status ports checked when set).
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic       sys_clk    = 1'b0;
    logic       sys_rst_l  = 1'b0;
    logic       wr_enH     = 1'b0;
    logic [7:0] wr_dataH   = 8'h00;
    logic       xmit_doneH = 1'b1;
    logic       fullH;
    logic       emptyH;
    logic       tx_idleH;
    logic       xmitH;
    logic [7:0] xmit_dataH;
`ifdef UART_TXF_STATUS_EN
    logic [AW:0] txf_levelH;
    logic        ovflH;
`endif

    always #5 sys_clk = ~sys_clk;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_l  (sys_rst_l),
        .wr_enH     (wr_enH),
        .wr_dataH   (wr_dataH),
        .fullH      (fullH),
        .emptyH     (emptyH),
        .tx_idleH   (tx_idleH),
        .xmitH      (xmitH),
        .xmit_dataH (xmit_dataH),
        .xmit_doneH (xmit_doneH)
`ifdef UART_TXF_STATUS_EN
        ,
        .txf_levelH (txf_levelH),
        .ovflH      (ovflH)
`endif
    );

    typedef struct {
        logic       wrEn;
        logic [7:0] data;
        logic       accept;
        logic       expFull;
        logic       expEmpty;
        int         expLevel;
    } vec_t;

    vec_t       vecs [17];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] sbQ [$];
    int         xmitCount = 0;
    logic       done = 1'b0;
    logic       prevXmit = 1'b0;
    logic [7:0] lastData = 8'h00;

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic writeByte(input logic [7:0] d);
        sbQ.push_back(d);
        wr_enH   = 1'b1;
        wr_dataH = d;
        tick();
        wr_enH   = 1'b0;
    endtask

    task automatic waitXmit(input string name);
        int n = 0;
        while (xmitH !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checkBit(name, xmitH, 1'b1);
    endtask

    // Transmitter model: busy for len cycles, then done, ending in IDLE.
    task automatic finishFrame(input int len);
        xmit_doneH = 1'b0;
        repeat (len) tick();
        xmit_doneH = 1'b1;
        tick();
    endtask

    task automatic monitor();
        while (!done) begin
            @(negedge sys_clk);
            if (xmitH === 1'b1) begin
                xmitCount++;
                checkBit("xmit_pulse_width", prevXmit, 1'b0);
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL xmit_order: unexpected xmitH with data 0x%02h, expected no issue", xmit_dataH);
                end else begin
                    checkInt("xmit_order", int'(xmit_dataH), int'(sbQ.pop_front()));
                end
            end else if (sys_rst_l) begin
                checkInt("xmit_data_hold", int'(xmit_dataH), int'(lastData));
            end
            prevXmit = xmitH;
            lastData = xmit_dataH;
        end
    endtask

    task automatic mainSeq();
        int savedCount;

        // Reset state
        #3;
        checkBit("rst_emptyH", emptyH, 1'b1);
        checkBit("rst_fullH", fullH, 1'b0);
        checkBit("rst_tx_idleH", tx_idleH, 1'b1);
        checkBit("rst_xmitH", xmitH, 1'b0);
        checkInt("rst_xmit_dataH", int'(xmit_dataH), 0);
`ifdef UART_TXF_STATUS_EN
        checkInt("rst_level", int'(txf_levelH), 0);
        checkBit("rst_ovflH", ovflH, 1'b0);
`endif
        tick();
        tick();
        sys_rst_l = 1'b1;

        // Single byte latency: write at edge N, xmitH after edge N+1
        writeByte(8'hA5);
        checkBit("lat_xmit_n", xmitH, 1'b0);
        checkBit("lat_empty_n", emptyH, 1'b0);
        tick();
        checkBit("lat_xmit_n1", xmitH, 1'b1);
        checkInt("lat_data_n1", int'(xmit_dataH), 8'hA5);
        checkBit("lat_empty_n1", emptyH, 1'b1);
        tick();
        checkBit("lat_xmit_n2", xmitH, 1'b0);
        xmit_doneH = 1'b0;
        tick();
        repeat (5) tick();
        checkInt("lat_data_wait_done", int'(xmit_dataH), 8'hA5);
        checkBit("lat_busy_not_idle", tx_idleH, 1'b0);
        xmit_doneH = 1'b1;
        tick();
        checkBit("lat_back_idle", tx_idleH, 1'b1);

        // Three back-to-back bytes, 160-cycle frames
        sbQ.push_back(8'h01);
        sbQ.push_back(8'h02);
        sbQ.push_back(8'h03);
        wr_enH = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wr_dataH = 8'(k);
            tick();
        end
        wr_enH = 1'b0;
        finishFrame(160);
        checkBit("seq3_after_first_empty", emptyH, 1'b0);
        checkBit("seq3_after_first_idle", tx_idleH, 1'b0);
`ifdef UART_TXF_STATUS_EN
        checkInt("seq3_level_two", int'(txf_levelH), 2);
`endif
        for (int k = 0; k < 2; k++) begin
            waitXmit("seq3_issue_timeout");
            finishFrame(160);
        end
        checkBit("seq3_tx_idle_end", tx_idleH, 1'b1);
        checkInt("seq3_issue_count", xmitCount, 4);
        checkInt("seq3_sb_drained", sbQ.size(), 0);

        // Fill to full with the transmitter never going busy
        for (int i = 0; i < 17; i++) begin
            vecs[i].wrEn     = 1'b1;
            vecs[i].data     = 8'(8'h60 + i);
            vecs[i].accept   = (i < DEPTH);
            vecs[i].expFull  = (i >= DEPTH - 1);
            vecs[i].expEmpty = 1'b0;
            vecs[i].expLevel = (i + 1 < DEPTH) ? i + 1 : DEPTH;
        end
        writeByte(8'h50);
        tick();
        tick();
        savedCount = xmitCount;
        for (int i = 0; i < 17; i++) begin
            wr_enH   = vecs[i].wrEn;
            wr_dataH = vecs[i].data;
            if (vecs[i].accept) sbQ.push_back(vecs[i].data);
            tick();
            checkBit("fill_fullH", fullH, vecs[i].expFull);
            checkBit("fill_emptyH", emptyH, vecs[i].expEmpty);
            checkBit("fill_xmitH", xmitH, 1'b0);
`ifdef UART_TXF_STATUS_EN
            checkInt("fill_level", int'(txf_levelH), vecs[i].expLevel);
`endif
        end
        wr_enH = 1'b0;
        checkInt("fill_no_issue", xmitCount, savedCount);
`ifdef UART_TXF_STATUS_EN
        checkBit("fill_ovflH", ovflH, 1'b1);
`endif

        // Full FIFO: write and pop in the same cycle
        xmit_doneH = 1'b0;
        tick();
        xmit_doneH = 1'b1;
        tick();
        checkBit("fullpop_pre_full", fullH, 1'b1);
        wr_enH   = 1'b1;
        wr_dataH = 8'hEE;
        tick();
        wr_enH   = 1'b0;
        checkBit("fullpop_fullH", fullH, 1'b0);
        checkBit("fullpop_xmitH", xmitH, 1'b1);
`ifdef UART_TXF_STATUS_EN
        checkInt("fullpop_level", int'(txf_levelH), 15);
`endif
        finishFrame(3);
        for (int k = 1; k < DEPTH; k++) begin
            waitXmit("drain_issue_timeout");
            finishFrame(3);
        end
        checkBit("drain_tx_idle", tx_idleH, 1'b1);
        checkInt("drain_sb_empty", sbQ.size(), 0);

        // Reset during WAIT_DONE with five bytes queued
        wr_enH = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wr_dataH = 8'(8'h80 + k);
            sbQ.push_back(wr_dataH);
            tick();
        end
        wr_enH = 1'b0;
        xmit_doneH = 1'b0;
        tick();
        tick();
        checkBit("midrst_pre_idle", tx_idleH, 1'b0);
`ifdef UART_TXF_STATUS_EN
        checkInt("midrst_pre_level", int'(txf_levelH), 5);
`endif
        checkInt("midrst_queued", sbQ.size(), 5);
        #2;
        sys_rst_l = 1'b0;
        #1;
        checkBit("midrst_emptyH", emptyH, 1'b1);
        checkBit("midrst_xmitH", xmitH, 1'b0);
        checkBit("midrst_fullH", fullH, 1'b0);
        checkBit("midrst_tx_idleH", tx_idleH, 1'b1);
        checkInt("midrst_data", int'(xmit_dataH), 0);
`ifdef UART_TXF_STATUS_EN
        checkBit("midrst_ovfl_clear", ovflH, 1'b0);
`endif
        sbQ.delete();
        tick();
        tick();
        sys_rst_l = 1'b1;
        xmit_doneH = 1'b1;
        savedCount = xmitCount;
        repeat (30) tick();
        checkInt("midrst_no_issue", xmitCount, savedCount);
        checkBit("midrst_idle_after", tx_idleH, 1'b1);
        writeByte(8'h99);
        waitXmit("post_rst_issue_timeout");
        finishFrame(4);
        checkInt("post_rst_sb_empty", sbQ.size(), 0);
        checkBit("post_rst_idle", tx_idleH, 1'b1);

        done = 1'b1;
        tick();
    endtask

    initial begin
        fork
            monitor();
            mainSeq();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
